// File: rtl/mem_stream_rr_arbiter_if.sv
// Request/response bundle between NumReq stream masters, the arbiter and one memory port.
interface mem_stream_rr_arbiter_if #(
  parameter int  NumReq     = 4,
  parameter type mem_req_t  = logic,
  parameter type mem_resp_t = logic
);
  mem_req_t            req_i [NumReq];
  logic [NumReq-1:0]   req_valid_i;
  logic [NumReq-1:0]   req_ready_o;
  mem_resp_t           resp_o;
  logic [NumReq-1:0]   resp_valid_o;
  logic [NumReq-1:0]   resp_ready_i;
  mem_req_t            mem_req_o;
  logic                mem_req_valid_o;
  logic                mem_req_ready_i;
  mem_resp_t           mem_resp_i;
  logic                mem_resp_valid_i;

  modport slave (
    input  req_i, req_valid_i, resp_ready_i, mem_req_ready_i, mem_resp_i, mem_resp_valid_i,
    output req_ready_o, resp_o, resp_valid_o, mem_req_o, mem_req_valid_o
  );

  modport master (
    output req_i, req_valid_i, resp_ready_i, mem_req_ready_i, mem_resp_i, mem_resp_valid_i,
    input  req_ready_o, resp_o, resp_valid_o, mem_req_o, mem_req_valid_o
  );
endinterface

// File: rtl/mem_stream_rr_arbiter.sv
// Round-robin share of one memory port among NumReq streams, with in-order response routing
// through an issuer-ID FIFO and a fall-through response FIFO (memory responses cannot stall).
module mem_stream_rr_arbiter #(
  parameter int  NumReq         = 4,
  parameter int  MaxOutstanding = 2,
  parameter type mem_req_t      = logic,
  parameter type mem_resp_t     = logic
) (
  input logic                    clk_i,
  input logic                    rst_i,
  mem_stream_rr_arbiter_if.slave bus
);
  localparam int ReqW = $clog2(NumReq);
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);
  localparam logic [ReqW-1:0] LastReq = ReqW'(NumReq - 1);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == LastPtr) return {PtrW{1'b0}};
    else              return p + PtrW'(1);
  endfunction

  // Highest-priority valid index starting at 'start'; scanning backwards lets the nearest win.
  function automatic logic [ReqW-1:0] rr_pick(input logic [NumReq-1:0] valid,
                                              input logic [ReqW-1:0]   start);
    logic [ReqW-1:0] pick;
    logic [ReqW-1:0] idx;
    pick = {ReqW{1'b0}};
    for (int i = NumReq - 1; i >= 0; i--) begin
      idx = ReqW'((int'(start) + i) % NumReq);
      if (valid[idx]) pick = idx;
      else            pick = pick;
    end
    return pick;
  endfunction

  logic [ReqW-1:0] r_rr;
  logic            r_lock;
  logic [ReqW-1:0] r_lock_idx;
  logic [CntW-1:0] r_cnt;
  logic [ReqW-1:0] r_id_mem [MaxOutstanding];
  logic [PtrW-1:0] r_id_wr, r_id_rd;
  mem_resp_t       r_rsp_mem [MaxOutstanding];
  logic [PtrW-1:0] r_rsp_wr, r_rsp_rd;
  logic [CntW-1:0] r_rcnt;

  logic [ReqW-1:0] w_winner;
  logic [ReqW-1:0] w_id_head;
  logic            w_resp_acc, w_resp_nempty, w_resp_pop;
  logic            w_can_issue, w_mem_req_valid, w_hs;
  mem_req_t        w_mem_req;

  // Issue gate, arbitration and response-side status; outputs are forced idle during reset.
  always_comb begin
    w_resp_acc      = bus.mem_resp_valid_i && (r_cnt != {CntW{1'b0}}) && (r_rcnt != MaxCnt);
    w_resp_nempty   = (r_rcnt != {CntW{1'b0}}) || w_resp_acc;
    w_id_head       = r_id_mem[r_id_rd];
    w_resp_pop      = !rst_i && w_resp_nempty && bus.resp_ready_i[w_id_head];
    w_can_issue     = (r_cnt < MaxCnt) || w_resp_pop;
    w_winner        = r_lock ? r_lock_idx : rr_pick(bus.req_valid_i, r_rr);
    w_mem_req_valid = !rst_i && w_can_issue && bus.req_valid_i[w_winner];
    w_hs            = w_mem_req_valid && bus.mem_req_ready_i;
    w_mem_req       = bus.req_i[w_winner];
  end

  always_comb begin
    bus.mem_req_o       = w_mem_req;
    bus.mem_req_valid_o = w_mem_req_valid;
    bus.req_ready_o     = {NumReq{1'b0}};
    if (!rst_i && w_can_issue && bus.mem_req_ready_i) bus.req_ready_o[w_winner] = 1'b1;
    else                                              bus.req_ready_o = {NumReq{1'b0}};
    bus.resp_valid_o    = {NumReq{1'b0}};
    if (!rst_i && w_resp_nempty) bus.resp_valid_o[w_id_head] = 1'b1;
    else                         bus.resp_valid_o = {NumReq{1'b0}};
    if (r_rcnt != {CntW{1'b0}}) bus.resp_o = r_rsp_mem[r_rsp_rd];
    else if (w_resp_acc)        bus.resp_o = bus.mem_resp_i;
    else                        bus.resp_o = '0;
  end

  // Grant pointer and lock: a stalled grant stays with its requester until accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr       <= {ReqW{1'b0}};
      r_lock     <= 1'b0;
      r_lock_idx <= {ReqW{1'b0}};
    end else if (w_hs) begin
      r_rr       <= (w_winner == LastReq) ? {ReqW{1'b0}} : w_winner + ReqW'(1);
      r_lock     <= 1'b0;
    end else if (w_mem_req_valid) begin
      r_lock     <= 1'b1;
      r_lock_idx <= w_winner;
    end else begin
      r_lock     <= r_lock;
    end
  end

  // Outstanding count; the ID FIFO occupancy always equals it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= {CntW{1'b0}};
    end else begin
      case ({w_hs, w_resp_pop})
        2'b10:   r_cnt <= r_cnt + CntW'(1);
        2'b01:   r_cnt <= r_cnt - CntW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Issuer-ID FIFO and response FIFO; an empty-FIFO push+pop passes straight through.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_id_wr  <= {PtrW{1'b0}};
      r_id_rd  <= {PtrW{1'b0}};
      r_rsp_wr <= {PtrW{1'b0}};
      r_rsp_rd <= {PtrW{1'b0}};
      r_rcnt   <= {CntW{1'b0}};
      for (int i = 0; i < MaxOutstanding; i++) begin
        r_id_mem[i]  <= {ReqW{1'b0}};
        r_rsp_mem[i] <= '0;
      end
    end else begin
      if (w_hs) begin
        r_id_mem[r_id_wr] <= w_winner;
        r_id_wr           <= ptr_inc(r_id_wr);
      end
      if (w_resp_acc) begin
        r_rsp_mem[r_rsp_wr] <= bus.mem_resp_i;
        r_rsp_wr            <= ptr_inc(r_rsp_wr);
      end
      if (w_resp_pop) begin
        r_id_rd  <= ptr_inc(r_id_rd);
        r_rsp_rd <= ptr_inc(r_rsp_rd);
      end
      case ({w_resp_acc, w_resp_pop})
        2'b10:   r_rcnt <= r_rcnt + CntW'(1);
        2'b01:   r_rcnt <= r_rcnt - CntW'(1);
        default: r_rcnt <= r_rcnt;
      endcase
    end
  end

  mem_stream_rr_arbiter_chk #(.CntW(CntW), .MaxCnt(MaxCnt)) u_chk (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .mem_resp_valid_i (bus.mem_resp_valid_i),
    .cnt_i            (r_cnt),
    .rcnt_i           (r_rcnt),
    .hs_i             (w_hs),
    .pop_i            (w_resp_pop)
  );
endmodule

// Protocol checks: dropped memory responses and counter wrap.
module mem_stream_rr_arbiter_chk #(
  parameter int              CntW   = 2,
  parameter logic [CntW-1:0] MaxCnt = 2'd2
) (
  input logic            clk_i,
  input logic            rst_i,
  input logic            mem_resp_valid_i,
  input logic [CntW-1:0] cnt_i,
  input logic [CntW-1:0] rcnt_i,
  input logic            hs_i,
  input logic            pop_i
);
  a_resp_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    !(mem_resp_valid_i && cnt_i == {CntW{1'b0}}));
  a_resp_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(mem_resp_valid_i && rcnt_i == MaxCnt));
  a_cnt_ovf: assert property (@(posedge clk_i) disable iff (rst_i)
    !(hs_i && !pop_i && cnt_i == MaxCnt));
  a_cnt_udf: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop_i && !hs_i && cnt_i == {CntW{1'b0}}));
endmodule
